// File: rtl/vad_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vad_capture_ctrl
//  Description : VAD-driven audio ring-buffer sequencer.
//                Every incoming PCM sample is written into an external
//                dual-port RAM ring. A speech onset opens a segment that
//                replays up to PRE_ROLL samples of history and then follows
//                live audio. The segment is delivered as one framed
//                valid/ready stream. It ends when speech falls or when
//                MAX_SEG samples have been taken. The read side is aborted
//                if the writer is about to lap the reader.
//  Ports       :
//    clk, rst_n        clock, asynchronous active-low reset
//    audio_in          16-bit signed PCM sample
//    sample_valid      one-cycle strobe per sample
//    speech_detected   VAD level decision (with hangover)
//    mem_we/waddr/wdata  ring write port (combinational from inputs)
//    mem_re/raddr      ring read port
//    mem_rdata         ring read data, valid one cycle after mem_re
//    out_data/valid/ready/last  segment output stream
//    seg_start         one-cycle pulse when a segment opens
//    seg_abort         one-cycle pulse when a segment is aborted by overrun
//    overrun           sticky overrun flag, cleared only by reset
//    seg_len           sample count of the last completed segment
//  Revision    : 1.0  initial release
// ============================================================================
module vad_capture_ctrl #(
    parameter int ADDR_W   = 13,     // ring depth = 2**ADDR_W, ADDR_W <= 14
    parameter int PRE_ROLL = 3200,   // history replayed at onset, < DEPTH-1
    parameter int MAX_SEG  = 32000   // forced segment end, < 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       audio_in,
    input  logic              sample_valid,
    input  logic              speech_detected,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [15:0]       mem_wdata,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              seg_start,
    output logic              seg_abort,
    output logic              overrun,
    output logic [15:0]       seg_len
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_CAPTURE    = 2'd1;
    localparam logic [1:0] ST_DRAIN      = 2'd2;
    localparam logic [1:0] ST_WAIT_QUIET = 2'd3;

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   FILL_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   OCC_FULL = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]   PRE_W    = PRE_ROLL[ADDR_W:0];
    localparam logic [15:0]       MAX_W    = MAX_SEG[15:0];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        state;
    logic              speech_prev;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   fill;        // writes since reset, saturating at DEPTH
    logic [ADDR_W:0]   occ;         // samples written but not yet read
    logic [15:0]       cnt;         // reads issued in this segment
    logic [15:0]       end_cnt;     // cnt value of the final sample
    logic              rd_pending;  // read issued last cycle, data now on bus
    logic [15:0]       rd_tag;      // segment index of the in-flight read
    logic [15:0]       out_tag;     // segment index of the sample on out_data

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic              onset;
    logic              falling;
    logic              active;
    logic              overrun_evt;
    logic              rd_issue;
    logic              handshake;
    logic              last_hs;
    logic              drain_empty;
    logic [ADDR_W:0]   pre_dist;
    logic [15:0]       seg_sum;

    assign onset       = speech_detected & ~speech_prev;
    assign falling     = speech_prev & ~speech_detected;
    assign active      = (state == ST_CAPTURE) || (state == ST_DRAIN);

    // The writer would land on the oldest unread sample on the next lap.
    assign overrun_evt = active && sample_valid && (occ == OCC_FULL);

    // Pre-roll is clipped to what has actually been written since reset.
    assign pre_dist    = (fill < PRE_W) ? fill : PRE_W;

    // Total samples claimed by this segment so far (read + still buffered).
    assign seg_sum     = cnt + {{(15-ADDR_W){1'b0}}, occ};

    // One read in flight at most; the output register must be free or
    // emptying this cycle so returned data never overwrites an unaccepted
    // sample. In DRAIN reading stops once the final sample has been issued.
    assign rd_issue    = active && !overrun_evt && (occ != '0) && !rd_pending
                         && (!out_valid || out_ready)
                         && ((state == ST_CAPTURE) || (cnt != end_cnt));

    assign handshake   = out_valid && out_ready;

    // The final sample is identified by its segment index, so it is marked
    // correctly even if the end decision arrives while it is already
    // in flight.
    assign out_last    = out_valid && (state == ST_DRAIN) && (out_tag == end_cnt);
    assign last_hs     = handshake && out_last;

    // Segment ended with nothing left to deliver (final sample already
    // accepted before the end decision, or an empty segment).
    assign drain_empty = (cnt == end_cnt) && !rd_pending && !out_valid;

    assign mem_we      = sample_valid;
    assign mem_waddr   = wr_ptr;
    assign mem_wdata   = audio_in;
    assign mem_re      = rd_issue;
    assign mem_raddr   = rd_ptr;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            speech_prev <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            occ         <= '0;
            cnt         <= '0;
            end_cnt     <= '0;
            rd_pending  <= 1'b0;
            rd_tag      <= '0;
            out_tag     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            seg_start   <= 1'b0;
            seg_abort   <= 1'b0;
            overrun     <= 1'b0;
            seg_len     <= '0;
        end else begin
            speech_prev <= speech_detected;
            seg_start   <= 1'b0;
            seg_abort   <= 1'b0;
            rd_pending  <= rd_issue;

            // Write side runs in every state.
            if (sample_valid) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (fill != FILL_MAX) begin
                    fill <= fill + CNT_ONE;
                end
            end

            // Read issue.
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                cnt    <= cnt + 16'd1;
                rd_tag <= cnt + 16'd1;
            end

            // Occupancy tracks the segment only; a concurrent write and
            // read cancel out.
            if (active) begin
                if (sample_valid && !rd_issue) begin
                    occ <= occ + CNT_ONE;
                end else if (!sample_valid && rd_issue) begin
                    occ <= occ - CNT_ONE;
                end
            end

            // Output register.
            if (handshake) begin
                out_valid <= 1'b0;
            end
            if (rd_pending && active) begin
                out_valid <= 1'b1;
                out_data  <= mem_rdata;
                out_tag   <= rd_tag;
            end

            case (state)
                ST_IDLE: begin
                    if (onset) begin
                        // A sample arriving on the onset cycle is written at
                        // the current wr_ptr and so belongs to the segment.
                        rd_ptr    <= wr_ptr - pre_dist[ADDR_W-1:0];
                        occ       <= pre_dist + {{ADDR_W{1'b0}}, sample_valid};
                        cnt       <= '0;
                        seg_start <= 1'b1;
                        state     <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    if (overrun_evt) begin
                        seg_abort  <= 1'b1;
                        overrun    <= 1'b1;
                        out_valid  <= 1'b0;
                        rd_pending <= 1'b0;
                        state      <= ST_WAIT_QUIET;
                    end else if (seg_sum >= MAX_W) begin
                        end_cnt <= MAX_W;
                        state   <= ST_DRAIN;
                    end else if (falling) begin
                        // A write on this very cycle is not yet in occ and
                        // is therefore excluded from the segment.
                        end_cnt <= seg_sum;
                        state   <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (overrun_evt) begin
                        seg_abort  <= 1'b1;
                        overrun    <= 1'b1;
                        out_valid  <= 1'b0;
                        rd_pending <= 1'b0;
                        state      <= ST_WAIT_QUIET;
                    end else if (last_hs || drain_empty) begin
                        seg_len <= end_cnt;
                        state   <= ST_IDLE;
                    end
                end

                ST_WAIT_QUIET: begin
                    // speech_prev keeps following the input, so a new
                    // segment needs a genuine rising edge after this.
                    if (!speech_detected) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vad_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vad_capture_ctrl
//  Description : Scoreboard bench for vad_capture_ctrl with a scaled ring
//                (DEPTH 256, pre-roll 100, max segment 500). Stimulus pushes
//                the expected output samples; a monitor pops them on every
//                stream handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vad_capture_ctrl;

    localparam int AW   = 8;
    localparam int PRE  = 100;
    localparam int MAXS = 500;

    logic          clk;
    logic          rst_n;
    logic [15:0]   audio_in;
    logic          sample_valid;
    logic          speech_detected;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [15:0]   mem_rdata;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          seg_start;
    logic          seg_abort;
    logic          overrun;
    logic [15:0]   seg_len;

    vad_capture_ctrl #(
        .ADDR_W   (AW),
        .PRE_ROLL (PRE),
        .MAX_SEG  (MAXS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .audio_in        (audio_in),
        .sample_valid    (sample_valid),
        .speech_detected (speech_detected),
        .mem_we          (mem_we),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata),
        .mem_re          (mem_re),
        .mem_raddr       (mem_raddr),
        .mem_rdata       (mem_rdata),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .seg_start       (seg_start),
        .seg_abort       (seg_abort),
        .overrun         (overrun),
        .seg_len         (seg_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External dual-port ring RAM.
    logic [15:0] ram [256];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_raddr];
    end

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   starts = 0;
    int   aborts = 0;
    int   gi     = 0;   // global sample index
    int   fill_m = 0;   // samples written since last reset
    int   seg_cnt = 0;
    bit   in_seg  = 0;
    bit   pushing = 1;
    int   rmode   = 1;  // 0: ready low, 1: ready high, 2: toggle

    function automatic logic [15:0] val(input int k);
        return 16'(k + 4096);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.last = 1'b0;
        e.data = val(k);
        exp_q.push_back(e);
    endtask

    task automatic onset();
        int d;
        d = (fill_m < PRE) ? fill_m : PRE;
        speech_detected = 1'b1;
        if (pushing) begin
            for (int k = gi - d; k < gi; k++) push_exp(k);
        end
        seg_cnt = d;
        in_seg  = 1'b1;
        tick();
    endtask

    // One sample followed by two idle cycles; optionally lower speech on the
    // cycle right after the sample so that sample closes the segment.
    task automatic send_one(input bit drop);
        sample_valid = 1'b1;
        audio_in     = val(gi);
        if (in_seg && seg_cnt < MAXS) begin
            if (pushing) push_exp(gi);
            seg_cnt++;
            if (seg_cnt == MAXS && pushing) exp_q[exp_q.size()-1].last = 1'b1;
        end
        gi++;
        fill_m++;
        tick();
        sample_valid = 1'b0;
        if (drop) begin
            speech_detected = 1'b0;
            if (in_seg && seg_cnt < MAXS && pushing) exp_q[exp_q.size()-1].last = 1'b1;
            in_seg = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 6000 && exp_q.size() != 0; i++) tick();
        chk("drain_done", exp_q.size(), 0);
        repeat (4) tick();
    endtask

    // ------------------------------------------------------------------------
    // Downstream ready driver
    // ------------------------------------------------------------------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ~out_ready;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    bit          hold_valid = 0;
    logic [15:0] hold_data  = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_valid = 0;
        end else begin
            if (seg_start) starts++;
            if (seg_abort) aborts++;
            if (hold_valid && !seg_abort)
                chk("stall_hold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, hold_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %0h expected none", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out", {15'd0, out_last, out_data}, {15'd0, e.last, e.data});
                end
            end
            hold_valid = out_valid && !out_ready;
            hold_data  = out_data;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int st0;
    int ab0;
    int nab;

    initial begin
        rst_n           = 1'b0;
        sample_valid    = 1'b0;
        audio_in        = '0;
        speech_detected = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last",  out_last, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_seg_start", seg_start, 0);
        chk("rst_seg_abort", seg_abort, 0);
        chk("rst_overrun",   overrun, 0);
        chk("rst_seg_len",   seg_len, 0);
        chk("rst_mem_re",    mem_re, 0);
        chk("rst_waddr",     mem_waddr, 0);
        chk("rst_raddr",     mem_raddr, 0);
        rst_n = 1'b1;
        tick();

        // Scenario 1: full pre-roll, live tail, speech falls.
        repeat (400) send_one(0);
        st0 = starts;
        onset();
        for (int i = 0; i < 150; i++) send_one(i == 149);
        wait_drain();
        chk("s1_seg_len", seg_len, 250);
        chk("s1_starts", starts - st0, 1);

        // Scenario 2: onset soon after reset, pre-roll clipped to fill.
        rst_n = 1'b0;
        tick();
        fill_m = 0;
        rst_n = 1'b1;
        tick();
        repeat (60) send_one(0);
        onset();
        for (int i = 0; i < 40; i++) send_one(i == 39);
        wait_drain();
        chk("s2_seg_len", seg_len, 100);

        // Scenario 3: speech held past the maximum segment length.
        repeat (50) send_one(0);
        st0 = starts;
        onset();
        repeat (600) send_one(0);
        wait_drain();
        chk("s3_seg_len", seg_len, 500);
        chk("s3_single_seg", starts - st0, 1);
        speech_detected = 1'b0;
        repeat (3) tick();

        // Scenario 5: downstream ready toggling every cycle.
        rmode = 2;
        onset();
        for (int i = 0; i < 80; i++) send_one(i == 79);
        wait_drain();
        chk("s5_seg_len", seg_len, 180);

        // Scenario 4: downstream stalled until the ring overruns.
        rmode   = 0;
        pushing = 0;
        tick();
        ab0 = aborts;
        st0 = starts;
        onset();
        nab = 0;
        for (int i = 1; i <= 200 && nab == 0; i++) begin
            send_one(0);
            if (aborts != ab0) nab = i;
        end
        in_seg = 0;
        chk("s4_abort_at", nab, 157);
        chk("s4_out_valid", out_valid, 0);
        chk("s4_overrun", overrun, 1);
        chk("s4_seg_len_kept", seg_len, 180);
        repeat (5) send_one(0);
        chk("s4_no_restart", starts - st0, 1);
        speech_detected = 1'b0;
        tick();
        tick();
        onset();
        tick();
        chk("s4_restart", starts - st0, 2);

        // Scenario 6: asynchronous reset in the middle of a drain.
        for (int i = 0; i < 20; i++) send_one(i == 19);
        tick();
        chk("s6_pending", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s6_out_valid", out_valid, 0);
        chk("s6_out_last",  out_last, 0);
        chk("s6_overrun",   overrun, 0);
        chk("s6_seg_len",   seg_len, 0);
        chk("s6_mem_re",    mem_re, 0);
        chk("s6_waddr",     mem_waddr, 0);
        exp_q.delete();
        fill_m = 0;
        in_seg = 0;
        tick();
        tick();
        rst_n   = 1'b1;
        rmode   = 1;
        pushing = 1;
        tick();
        st0 = starts;
        repeat (60) send_one(0);
        onset();
        for (int i = 0; i < 40; i++) send_one(i == 39);
        wait_drain();
        chk("s6_seg_len_after", seg_len, 100);
        chk("s6_starts_after", starts - st0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
